// File: rtl/rx_pkg.sv
// Shared constants and state encoding for the RX comma-alignment controller.
package rx_pkg;

    // K28.5 in both running disparities, written LSB-first as received.
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    // Last bit position of a 10-bit word.
    localparam logic [3:0] POS_LAST = 4'd9;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

    function automatic logic is_k28_5(input logic [9:0] w);
        return (w == K28_5_RDN) || (w == K28_5_RDP);
    endfunction

endpackage

// File: rtl/rx_comma_align_ctrl_if.sv
// Signal bundle between the RX datapath and the comma-alignment controller.
// RealignCnt exists only when RX_ALIGN_STATUS_EN is defined.
interface rx_comma_align_ctrl_if;
    logic       Serial;
    logic       AlignEn;
    logic       Comma;
    logic       Locked;
    logic       WordStrobe;
`ifdef RX_ALIGN_STATUS_EN
    logic [7:0] RealignCnt;

    modport master (
        output Serial, AlignEn,
        input  Comma, Locked, WordStrobe, RealignCnt
    );
    modport slave (
        input  Serial, AlignEn,
        output Comma, Locked, WordStrobe, RealignCnt
    );
`else
    modport master (
        output Serial, AlignEn,
        input  Comma, Locked, WordStrobe
    );
    modport slave (
        input  Serial, AlignEn,
        output Comma, Locked, WordStrobe
    );
`endif
endinterface

// File: rtl/rx_comma_detect.sv
// Serial K28.5 detector: 10-bit shift window, det flags a comma ending on the
// bit currently on Serial.
module rx_comma_detect
    import rx_pkg::*;
(
    input  logic BitCLK,
    input  logic Reset,
    input  logic Serial,
    output logic det
);

    // Bit 0 of the window would only ever be shifted out, so it is not stored.
    logic [9:1] window_reg;
    logic [9:0] next_win;

    assign next_win[9] = Serial;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_shift
            assign next_win[gi] = window_reg[gi+1];
        end
    endgenerate

    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            window_reg <= '0;
        end else begin
            window_reg <= next_win[9:1];
        end
    end

    assign det = is_k28_5(next_win);

endmodule

// File: rtl/rx_comma_align_ctrl.sv
// Word-alignment controller: hunts for K28.5, realigns the SIPO, qualifies lock.
// Optional RealignCnt status counter is built when RX_ALIGN_STATUS_EN is defined.
module rx_comma_align_ctrl
    import rx_pkg::*;
#(
    parameter int LOCK_COUNT    = 3,
    parameter int LOSS_COUNT    = 4,
    parameter int TIMEOUT_WORDS = 255
) (
    input logic                  BitCLK,
    input logic                  Reset,
    rx_comma_align_ctrl_if.slave rx
);

    localparam logic [2:0] LOCK_TARGET = 3'(LOCK_COUNT);
    localparam logic [2:0] LOSS_TARGET = 3'(LOSS_COUNT);
    localparam logic [7:0] TMO_TARGET  = 8'(TIMEOUT_WORDS);

    align_state_t state_reg, state_next;
    logic [3:0]   pos_reg, pos_next;
    logic [2:0]   good_cnt_reg, good_cnt_next;
    logic [2:0]   bad_cnt_reg, bad_cnt_next;
    logic [7:0]   tmo_cnt_reg, tmo_cnt_next;
    logic         locked_reg;
    logic         strobe_reg;

    logic         det;
    logic         pos_wrap;
    logic         aligned;
    logic         misaligned;
    logic         comma;
    logic [2:0]   good_inc;
    logic [2:0]   bad_inc;
    logic [7:0]   tmo_inc;

    rx_comma_detect u_detect (
        .BitCLK (BitCLK),
        .Reset  (Reset),
        .Serial (rx.Serial),
        .det    (det)
    );

    assign pos_wrap   = (pos_reg == POS_LAST);
    assign aligned    = det && pos_wrap;
    assign misaligned = det && !pos_wrap;
    assign good_inc   = good_cnt_reg + 3'd1;
    assign bad_inc    = bad_cnt_reg + 3'd1;
    assign tmo_inc    = tmo_cnt_reg + 8'd1;

    // Mealy output: the SIPO must see the request during the comma's last bit.
    assign comma = det && rx.AlignEn && (state_reg != LOCKED);

    always_comb begin
        pos_next = pos_reg + 4'd1;
        if (comma || pos_wrap) begin
            pos_next = 4'd0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;

        if (!rx.AlignEn) begin
            state_next    = HUNT;
            good_cnt_next = 3'd0;
            bad_cnt_next  = 3'd0;
            tmo_cnt_next  = 8'd0;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (det) begin
                        state_next    = CONFIRM;
                        good_cnt_next = 3'd1;
                        tmo_cnt_next  = 8'd0;
                    end
                end
                CONFIRM: begin
                    if (aligned) begin
                        good_cnt_next = good_inc;
                        tmo_cnt_next  = 8'd0;
                        if (good_inc == LOCK_TARGET) begin
                            state_next   = LOCKED;
                            bad_cnt_next = 3'd0;
                        end
                    end else if (misaligned) begin
                        good_cnt_next = 3'd1;
                        tmo_cnt_next  = 8'd0;
                    end else if (pos_wrap) begin
                        // A whole word passed without a comma on the boundary.
                        tmo_cnt_next = tmo_inc;
                        if (tmo_inc == TMO_TARGET) begin
                            state_next    = HUNT;
                            good_cnt_next = 3'd0;
                            tmo_cnt_next  = 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        bad_cnt_next = 3'd0;
                    end else if (misaligned) begin
                        bad_cnt_next = bad_inc;
                        if (bad_inc == LOSS_TARGET) begin
                            state_next    = HUNT;
                            bad_cnt_next  = 3'd0;
                            good_cnt_next = 3'd0;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            state_reg    <= HUNT;
            pos_reg      <= 4'd0;
            good_cnt_reg <= 3'd0;
            bad_cnt_reg  <= 3'd0;
            tmo_cnt_reg  <= 8'd0;
            locked_reg   <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            good_cnt_reg <= good_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            locked_reg   <= (state_next == LOCKED);
            strobe_reg   <= pos_wrap && locked_reg;
        end
    end

    assign rx.Comma      = comma;
    assign rx.Locked     = locked_reg;
    assign rx.WordStrobe = strobe_reg;

`ifdef RX_ALIGN_STATUS_EN
    logic [7:0] realign_cnt_reg;

    // Saturating count of realign requests; only Reset clears it.
    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            realign_cnt_reg <= 8'd0;
        end else if (comma && (realign_cnt_reg != 8'hFF)) begin
            realign_cnt_reg <= realign_cnt_reg + 8'd1;
        end
    end

    assign rx.RealignCnt = realign_cnt_reg;
`endif

endmodule

// File: tb/tb_rx_comma_align_ctrl.sv
// Bench for rx_comma_align_ctrl: table vectors, directed lock/loss/timeout/enable/reset
// sequences and a random stream, all checked every cycle against a word-level model.
module tb_rx_comma_align_ctrl;

    localparam logic [9:0] C_RDN = 10'h17C;
    localparam logic [9:0] C_RDP = 10'h283;
    localparam logic [9:0] DWORD = 10'h2AA;
    localparam int LOCK_N = 3;
    localparam int LOSS_N = 4;
    localparam int TMO_N  = 255;

    logic BitCLK = 1'b0;
    logic Reset;
    always #5 BitCLK = ~BitCLK;

    rx_comma_align_ctrl_if ifc ();

    rx_comma_align_ctrl #(
        .LOCK_COUNT    (LOCK_N),
        .LOSS_COUNT    (LOSS_N),
        .TIMEOUT_WORDS (TMO_N)
    ) dut (
        .BitCLK (BitCLK),
        .Reset  (Reset),
        .rx     (ifc)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    int n_pulse = 0;

    // Behavioural SIPO sharing Serial/Comma with the controller.
    logic [9:0] sipo_sr, sipo_par;
    int         sipo_cnt;
    always @(posedge BitCLK) begin
        if (Reset) begin
            sipo_sr  <= '0;
            sipo_par <= '0;
            sipo_cnt <= 0;
        end else begin
            sipo_sr <= {ifc.Serial, sipo_sr[9:1]};
            if (ifc.Comma === 1'b1 || sipo_cnt == 9) begin
                sipo_cnt <= 0;
                sipo_par <= {ifc.Serial, sipo_sr[9:1]};
            end else begin
                sipo_cnt <= sipo_cnt + 1;
            end
        end
    end

    // Reference model: bit history queue plus word phase and qualification counts.
    typedef enum int {M_HUNT, M_CONFIRM, M_LOCKED} mstate_e;
    mstate_e m_st;
    bit      m_hist[$];
    int      m_phase, m_good, m_bad, m_idle, m_realigns;
    bit      m_locked, m_strobe;

    task automatic m_reset();
        m_hist.delete();
        repeat (10) m_hist.push_back(1'b0);
        m_st = M_HUNT;
        m_phase = 0; m_good = 0; m_bad = 0; m_idle = 0; m_realigns = 0;
        m_locked = 1'b0; m_strobe = 1'b0;
    endtask

    function automatic bit m_det(input bit s);
        logic [9:0] v;
        v[9] = s;
        for (int k = 0; k < 9; k++) v[8-k] = m_hist[m_hist.size()-1-k];
        return (v == C_RDN) || (v == C_RDP);
    endfunction

    task automatic m_edge(input bit s, input bit en, input bit rst);
        bit det, comma, boundary;
        if (rst) begin
            m_reset();
            return;
        end
        det      = m_det(s);
        comma    = det && en && (m_st != M_LOCKED);
        boundary = (m_phase == 9);
        m_strobe = boundary && m_locked;
        if (comma && m_realigns < 255) m_realigns++;
        if (!en) begin
            m_st = M_HUNT; m_good = 0; m_bad = 0; m_idle = 0;
        end else begin
            case (m_st)
                M_HUNT: if (det) begin m_st = M_CONFIRM; m_good = 1; m_idle = 0; end
                M_CONFIRM: begin
                    if (det && boundary) begin
                        m_good++; m_idle = 0;
                        if (m_good == LOCK_N) begin m_st = M_LOCKED; m_bad = 0; end
                    end else if (det) begin
                        m_good = 1; m_idle = 0;
                    end else if (boundary) begin
                        m_idle++;
                        if (m_idle == TMO_N) begin m_st = M_HUNT; m_good = 0; m_idle = 0; end
                    end
                end
                default: begin
                    if (det && boundary) m_bad = 0;
                    else if (det) begin
                        m_bad++;
                        if (m_bad == LOSS_N) begin m_st = M_HUNT; m_bad = 0; m_good = 0; end
                    end
                end
            endcase
        end
        m_phase = (comma || boundary) ? 0 : m_phase + 1;
        m_hist.push_back(s);
        void'(m_hist.pop_front());
        m_locked = (m_st == M_LOCKED);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bit time: drive after the falling edge, check Comma, clock, check registers.
    task automatic cyc(input bit s, input bit en = 1'b1, input bit rst = 1'b0);
        bit exp_comma;
        ifc.Serial  = s;
        ifc.AlignEn = en;
        Reset       = rst;
        #1;
        exp_comma = m_det(s) && en && (m_st != M_LOCKED);
        if (chk_on) check("comma", ifc.Comma, exp_comma);
        if (ifc.Comma === 1'b1) n_pulse++;
        @(posedge BitCLK);
        m_edge(s, en, rst);
        @(negedge BitCLK);
        if (chk_on) begin
            check("locked", ifc.Locked, m_locked);
            check("strobe", ifc.WordStrobe, m_strobe);
`ifdef RX_ALIGN_STATUS_EN
            check("realign_cnt", ifc.RealignCnt, m_realigns);
`endif
        end
    endtask

    task automatic send_word(input logic [9:0] w, input bit en = 1'b1);
        for (int i = 0; i < 10; i++) cyc(w[i], en);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        check("rst_locked", ifc.Locked, 1'b0);
        check("rst_strobe", ifc.WordStrobe, 1'b0);
    endtask

    task automatic acquire(input int n_idle, input int n_commas);
        for (int i = 0; i < n_idle; i++) cyc(bit'(i % 2 == 0));
        for (int c = 0; c < n_commas; c++) begin
            send_word(C_RDN);
            send_word(DWORD);
        end
    endtask

    typedef struct {
        int n_idle;
        int n_commas;
        bit exp_locked;
        int exp_pulses;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [9:0] code;
        int r, gap;

        vecs[0] = '{3, 1, 1'b0, 1};
        vecs[1] = '{3, 2, 1'b0, 2};
        vecs[2] = '{3, 3, 1'b1, 3};
        vecs[3] = '{0, 5, 1'b1, 3};
        vecs[4] = '{7, 4, 1'b1, 3};
        vecs[5] = '{9, 0, 1'b0, 0};

        m_reset();
        ifc.Serial = 1'b0; ifc.AlignEn = 1'b1; Reset = 1'b1;
        @(negedge BitCLK);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk_on = 1'b1;

        // Acquisition from various offsets; comma codes alternate disparity.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            n_pulse = 0;
            for (int i = 0; i < vecs[v].n_idle; i++) cyc(bit'(i % 2 == 0));
            for (int c = 0; c < vecs[v].n_commas; c++) begin
                code = (c % 2 == 0) ? C_RDN : C_RDP;
                send_word(code);
                if (vecs[v].exp_locked && c == vecs[v].n_commas - 1)
                    check("vec_par", sipo_par, code);
                send_word(DWORD);
            end
            check("vec_locked", ifc.Locked, vecs[v].exp_locked);
            check("vec_pulses", n_pulse, vecs[v].exp_pulses);
            $display("vec %0d: idle=%0d commas=%0d locked=%0b pulses=%0d",
                     v, vecs[v].n_idle, vecs[v].n_commas, ifc.Locked, n_pulse);
        end

        // Lock loss after a one-bit slip, then relock.
        do_reset();
        acquire(3, 4);
        cyc(1'b0);
        n_pulse = 0;
        for (int c = 1; c <= 4; c++) begin
            send_word(C_RDN);
            check("loss_locked", ifc.Locked, bit'(c < 4));
            send_word(DWORD);
        end
        check("loss_pulses", n_pulse, 0);
        n_pulse = 0;
        for (int c = 1; c <= 3; c++) begin
            send_word(C_RDN);
            check("relock_locked", ifc.Locked, bit'(c == 3));
            send_word(DWORD);
        end
        check("relock_pulses", n_pulse, 3);
        $display("lock loss: relocked=%0b pulses=%0d", ifc.Locked, n_pulse);

        // CONFIRM timeout boundary: 254 idle words keep CONFIRM, 255 return to HUNT.
        for (int n = 254; n <= 255; n++) begin
            do_reset();
            acquire(3, 0);
            send_word(C_RDN);
            for (int w = 0; w < n; w++) send_word(DWORD);
            send_word(C_RDN);
            send_word(DWORD);
            send_word(C_RDN);
            check("tmo_locked", ifc.Locked, bit'(n == 254));
            $display("timeout: idle_words=%0d locked=%0b", n, ifc.Locked);
        end

        // Enable drop while locked.
        do_reset();
        acquire(3, 3);
        check("en_prelock", ifc.Locked, 1'b1);
        n_pulse = 0;
        cyc(1'b0, 1'b0);
        check("en_drop_locked", ifc.Locked, 1'b0);
        for (int c = 0; c < 4; c++) begin
            send_word(C_RDN, 1'b0);
            send_word(DWORD, 1'b0);
        end
        check("en_drop_pulses", n_pulse, 0);
        acquire(0, 3);
        check("en_restore_locked", ifc.Locked, 1'b1);
        $display("enable drop: pulses_while_off=0 relocked=%0b", ifc.Locked);

        // Reset mid-CONFIRM, then re-acquire.
        do_reset();
        acquire(3, 1);
        send_word(C_RDP);
        for (int i = 0; i < 4; i++) cyc(DWORD[i]);
        cyc(1'b1, 1'b1, 1'b1);
        check("midrst_locked", ifc.Locked, 1'b0);
        check("midrst_strobe", ifc.WordStrobe, 1'b0);
        ifc.Serial = 1'b1;
        #1;
        check("midrst_comma", ifc.Comma, 1'b0);
        n_pulse = 0;
        acquire(3, 3);
        check("midrst_relock", ifc.Locked, 1'b1);
        check("midrst_pulses", n_pulse, 3);
        $display("mid-confirm reset: relocked=%0b pulses=%0d", ifc.Locked, n_pulse);

`ifdef RX_ALIGN_STATUS_EN
        // 301 realign requests must saturate the status counter.
        do_reset();
        send_word(C_RDN);
        for (int c = 0; c < 300; c++) begin
            cyc(1'b1);
            send_word(C_RDN);
        end
        check("realign_sat", ifc.RealignCnt, 8'd255);
        $display("status counter: RealignCnt=%0d", ifc.RealignCnt);
`endif

        // Random stream: mostly periodic commas, random slips, data, enable drops, resets.
        do_reset();
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cyc(bit'($urandom_range(0, 1)), 1'b1, 1'b1);
            end else if (r < 8) begin
                gap = $urandom_range(1, 15);
                for (int i = 0; i < gap; i++) cyc(bit'($urandom_range(0, 1)), 1'b0);
            end else if (r < 50) begin
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                for (int i = 0; i < gap; i++) cyc(bit'($urandom_range(0, 1)));
                send_word($urandom_range(0, 1) ? C_RDN : C_RDP);
            end else begin
                send_word(10'($urandom));
            end
        end
        $display("random: 400 segments, checks so far=%0d", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
